knn_data_feeder: RTL and testbench
==================================

KNN_DATA_FEEDER -- requirements
Module: knn_data_feeder

Interface
REQ-001 SHALL have parameters: M, default 5, matrix rows; N, default 10, matrix columns; W, default 32, element width; MAX_ELEMENTS, default 64, elements per burst; TYPE_W, default 3, class label width; L, default 6, log2 of the training sample count.
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a full feed of 2^L samples.
- data_request  in  1  KNN core ready for the next burst.
- done  in  1  KNN core finished the current sample.
- inference_done  in  1  KNN core produced the inferred type.
- trn_addr  out  L+clog2(M*N)  training memory address.
- trn_rdata  in  W  training memory data, 1-cycle latency.
- inp_addr  out  clog2(M*N)  input memory address.
- inp_rdata  in  W  input memory data, 1-cycle latency.
- type_addr  out  L  label memory address.
- type_rdata  in  TYPE_W  label memory data, 1-cycle latency.
- training_data  out  W*M*N  burst bus.
- input_data  out  W*M*N  burst bus.
- training_data_type  out  TYPE_W  label of the current sample.
- read_done  out  1  one-cycle burst-valid strobe.
- busy  out  1  feed in progress.
- feed_done  out  1  one-cycle completion strobe.
REQ-003 SHALL use one clock (clk) and a synchronous active-high reset (rst).

Function
REQ-004 SHALL use these derived constants: E=M*N; C=min(E,MAX_ELEMENTS); NB=ceil(E/MAX_ELEMENTS).
REQ-005 SHALL use states IDLE, FETCH, PRESENT, WAIT_REQ, WAIT_DONE, WAIT_INF.
REQ-006 IDLE: start=1 SHALL move the block to FETCH with sample=0, element=0, busy=1; start SHALL be ignored outside IDLE.
REQ-007 FETCH SHALL issue one element address per cycle: trn_addr=sample*E+element, inp_addr=element.
REQ-008 On the first burst of each sample, type_addr=sample SHALL be issued in the first FETCH cycle, and type_rdata SHALL be latched into training_data_type.
REQ-009 Returned word k of the burst SHALL be written to bits [W*(k+1)-1 -: W] of both buses; unused upper words SHALL hold 0.
REQ-010 A burst SHALL hold min(C, E-element) words.
REQ-011 read_done SHALL be high for exactly one cycle, starting C+1 clock edges after the edge that entered FETCH (PRESENT state).
REQ-012 Bus contents SHALL be stable from read_done until the next FETCH begins.
REQ-013 After PRESENT: if elements remain in the sample, go to WAIT_REQ; otherwise go to WAIT_DONE.
REQ-014 data_request and done SHALL be sampled only from the cycle after read_done; a level high in the read_done cycle SHALL be ignored.
REQ-015 WAIT_REQ: data_request=1 SHALL move to FETCH and continue the element count.
REQ-016 WAIT_DONE: done=1 moves to FETCH with sample+1, element=0; on the last sample (2^L-1) it moves to WAIT_INF instead.
REQ-017 WAIT_INF: inference_done=1 SHALL pulse feed_done for one cycle, clear busy and return to IDLE.
REQ-018 Unexpected data_request, done or inference_done in other states SHALL be ignored.
REQ-019 Sample and element counters SHALL wrap only through reset or IDLE; no address SHALL exceed 2^L*E-1.

Reset
REQ-020 rst=1 at any clock edge SHALL force IDLE and clear all outputs, counters and buses to 0, including mid-FETCH and mid-wait.
REQ-021 Reset SHALL take priority over start and all handshake inputs in the same cycle.

Structure
REQ-022 A shared package knn_pkg SHALL hold the state enum and the E/C/NB computation functions, shared with knn_system.
REQ-023 One sub-module, knn_fetch_ctr (sample/element/burst counters plus address generation), is natural; the FSM and bus registers SHALL stay in knn_data_feeder.

Verification
REQ-024 M=5, N=10, MAX_ELEMENTS=64, L=6, start: 64 single bursts of 50 words; read_done rises 51 edges after start; each word matches memory; feed_done after inference_done.
REQ-025 M=N=10, MAX_ELEMENTS=64: per sample, a 64-word burst then wait for data_request, then a 36-word burst with words 36..63=0; trn_addr for sample 3 spans 300..399.
REQ-026 done held high continuously, including the read_done cycle: each sample advances exactly once; no burst is skipped.
REQ-027 rst asserted 10 cycles into FETCH of sample 5: next cycle all outputs 0, state IDLE; a new start restarts at sample 0, addr 0.
REQ-028 start pulsed while busy, and inference_done pulsed during WAIT_DONE: both ignored; feed_done pulses once, only in WAIT_INF.

Source files
------------

// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared state encoding and burst geometry helpers for the KNN feeder
package knn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRESENT,
        ST_WAIT_REQ,
        ST_WAIT_DONE,
        ST_WAIT_INF
    } knn_state_t;

    // Elements per sample (E)
    function automatic int knn_elements(input int m, input int n);
        return m * n;
    endfunction

    // Words carried by a full burst (C)
    function automatic int knn_burst_words(input int e, input int max_elements);
        return (e < max_elements) ? e : max_elements;
    endfunction

    // Bursts needed to cover one sample (NB)
    function automatic int knn_num_bursts(input int e, input int max_elements);
        return (e + max_elements - 1) / max_elements;
    endfunction

endpackage

// File: rtl/knn_fetch_ctr.sv
// rtl/knn_fetch_ctr.sv - sample/element/word counters and memory address generation
module knn_fetch_ctr #(
    parameter int E = 50,
    parameter int C = 50,
    parameter int L = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clr,
    input  logic                       i_fetch,
    input  logic                       i_burst_adv,
    input  logic                       i_sample_adv,
    output logic [$clog2(E+1)-1:0]     o_word,
    output logic                       o_issue,
    output logic                       o_fetch_last,
    output logic                       o_more,
    output logic                       o_first_burst,
    output logic                       o_last_sample,
    output logic [L+$clog2(E)-1:0]     o_trn_addr,
    output logic [$clog2(E)-1:0]       o_inp_addr,
    output logic [L-1:0]               o_type_addr
);

    localparam int EW = $clog2(E + 1);
    localparam int IW = $clog2(E);
    localparam int AW = L + IW;
    localparam logic [EW-1:0] E_V = EW'(E);
    localparam logic [EW-1:0] C_V = EW'(C);

    logic [L-1:0]  r_sample;
    logic [EW-1:0] r_element;
    logic [EW-1:0] r_word;
    logic [EW-1:0] w_rem;
    logic [EW-1:0] w_len;
    logic [EW-1:0] w_off;
    logic [EW-1:0] w_elem_off;

    // Burst length and the in-sample offset; the offset holds on the last word
    // during the capture cycle so no address ever leaves the sample
    always_comb begin
        w_rem      = E_V - r_element;
        w_len      = (w_rem < C_V) ? w_rem : C_V;
        w_off      = (r_word < w_len) ? r_word : (w_len - EW'(1));
        w_elem_off = r_element + w_off;
    end

    assign o_word        = r_word;
    assign o_issue       = (r_word < w_len);
    assign o_fetch_last  = (r_word == w_len);
    assign o_more        = ((r_element + w_len) < E_V);
    assign o_first_burst = (r_element == '0);
    assign o_last_sample = (r_sample == '1);
    assign o_trn_addr    = AW'(r_sample) * AW'(E) + AW'(w_elem_off);
    assign o_inp_addr    = IW'(w_elem_off);
    assign o_type_addr   = r_sample;

    // Word offset runs only inside FETCH; element/sample advance between bursts
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_sample  <= '0;
            r_element <= '0;
            r_word    <= '0;
        end else begin
            if (!i_fetch) begin
                r_word <= '0;
            end else if (r_word < w_len) begin
                r_word <= r_word + EW'(1);
            end
            if (i_sample_adv) begin
                r_sample  <= r_sample + L'(1);
                r_element <= '0;
            end else if (i_burst_adv) begin
                r_element <= r_element + w_len;
            end
        end
    end

endmodule

// File: rtl/knn_data_feeder.sv
// rtl/knn_data_feeder.sv - bursts training/input samples from memory to the KNN core
module knn_data_feeder
    import knn_pkg::*;
#(
    parameter int M            = 5,
    parameter int N            = 10,
    parameter int W            = 32,
    parameter int MAX_ELEMENTS = 64,
    parameter int TYPE_W       = 3,
    parameter int L            = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       data_request,
    input  logic                       done,
    input  logic                       inference_done,
    output logic [L+$clog2(M*N)-1:0]   trn_addr,
    input  logic [W-1:0]               trn_rdata,
    output logic [$clog2(M*N)-1:0]     inp_addr,
    input  logic [W-1:0]               inp_rdata,
    output logic [L-1:0]               type_addr,
    input  logic [TYPE_W-1:0]          type_rdata,
    output logic [W*M*N-1:0]           training_data,
    output logic [W*M*N-1:0]           input_data,
    output logic [TYPE_W-1:0]          training_data_type,
    output logic                       read_done,
    output logic                       busy,
    output logic                       feed_done
);

    localparam int E  = knn_elements(M, N);
    localparam int C  = knn_burst_words(E, MAX_ELEMENTS);
    localparam int EW = $clog2(E + 1);

    knn_state_t        r_state;
    knn_state_t        w_next;
    logic              w_clr;
    logic              w_fetch;
    logic              w_fetch_entry;
    logic              w_burst_adv;
    logic              w_sample_adv;
    logic [EW-1:0]     w_word;
    logic              w_issue;
    logic              w_fetch_last;
    logic              w_more;
    logic              w_first_burst;
    logic              w_last_sample;
    logic              r_cap_valid;
    logic [EW-1:0]     r_cap_idx;
    logic [W*E-1:0]    r_training_data;
    logic [W*E-1:0]    r_input_data;
    logic [TYPE_W-1:0] r_type;
    logic              r_feed_done;

    knn_fetch_ctr #(
        .E (E),
        .C (C),
        .L (L)
    ) u_ctr (
        .clk           (clk),
        .rst           (rst),
        .i_clr         (w_clr),
        .i_fetch       (w_fetch),
        .i_burst_adv   (w_burst_adv),
        .i_sample_adv  (w_sample_adv),
        .o_word        (w_word),
        .o_issue       (w_issue),
        .o_fetch_last  (w_fetch_last),
        .o_more        (w_more),
        .o_first_burst (w_first_burst),
        .o_last_sample (w_last_sample),
        .o_trn_addr    (trn_addr),
        .o_inp_addr    (inp_addr),
        .o_type_addr   (type_addr)
    );

    assign w_fetch       = (r_state == ST_FETCH);
    assign w_fetch_entry = (w_next == ST_FETCH) && (r_state != ST_FETCH);

    // Next-state and counter control; handshakes only matter in their own wait state
    always_comb begin
        w_next       = r_state;
        w_clr        = 1'b0;
        w_burst_adv  = 1'b0;
        w_sample_adv = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_FETCH;
                    w_clr  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (w_fetch_last) begin
                    w_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (w_more) begin
                    w_next      = ST_WAIT_REQ;
                    w_burst_adv = 1'b1;
                end else begin
                    w_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_REQ: begin
                if (data_request) begin
                    w_next = ST_FETCH;
                end
            end
            ST_WAIT_DONE: begin
                if (done) begin
                    if (w_last_sample) begin
                        w_next = ST_WAIT_INF;
                    end else begin
                        w_next       = ST_FETCH;
                        w_sample_adv = 1'b1;
                    end
                end
            end
            ST_WAIT_INF: begin
                if (inference_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory has one cycle of latency, so remember which word each issued address fills
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_valid <= 1'b0;
            r_cap_idx   <= '0;
        end else begin
            r_cap_valid <= w_fetch && w_issue;
            r_cap_idx   <= w_word;
        end
    end

    // Burst buses: cleared when a fetch begins, then filled word by word
    always_ff @(posedge clk) begin
        if (rst || w_fetch_entry) begin
            r_training_data <= '0;
            r_input_data    <= '0;
        end else if (r_cap_valid) begin
            for (int k = 0; k < C; k++) begin
                if (r_cap_idx == EW'(k)) begin
                    r_training_data[k*W +: W] <= trn_rdata;
                    r_input_data[k*W +: W]    <= inp_rdata;
                end
            end
        end
    end

    // Label arrives alongside word 0 of the first burst of a sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_type <= '0;
        end else if (r_cap_valid && (r_cap_idx == '0) && w_first_burst) begin
            r_type <= type_rdata;
        end
    end

    // One-cycle completion strobe after the core reports its inference
    always_ff @(posedge clk) begin
        if (rst) begin
            r_feed_done <= 1'b0;
        end else begin
            r_feed_done <= (r_state == ST_WAIT_INF) && inference_done;
        end
    end

    assign training_data      = r_training_data;
    assign input_data         = r_input_data;
    assign training_data_type = r_type;
    assign read_done          = (r_state == ST_PRESENT);
    assign busy               = (r_state != ST_IDLE);
    assign feed_done          = r_feed_done;

endmodule

// File: tb/tb_knn_data_feeder.sv
// tb/tb_knn_data_feeder.sv - self-checking bench for knn_data_feeder
module tb_knn_data_feeder;

    localparam int M    = 10;
    localparam int N    = 10;
    localparam int W    = 32;
    localparam int MAXE = 64;
    localparam int TW   = 3;
    localparam int L    = 3;
    localparam int E    = M * N;
    localparam int C    = (E < MAXE) ? E : MAXE;
    localparam int NB   = (E + MAXE - 1) / MAXE;
    localparam int NS   = 1 << L;
    localparam int IW   = $clog2(E);
    localparam int AW   = L + IW;

    typedef struct {
        int s;
        int b;
        int tlo;
        int thi;
        int ilo;
        int ihi;
        int lat;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            data_request;
    logic            done;
    logic            inference_done;
    logic [AW-1:0]   trn_addr;
    logic [W-1:0]    trn_rdata;
    logic [IW-1:0]   inp_addr;
    logic [W-1:0]    inp_rdata;
    logic [L-1:0]    type_addr;
    logic [TW-1:0]   type_rdata;
    logic [W*E-1:0]  training_data;
    logic [W*E-1:0]  input_data;
    logic [TW-1:0]   training_data_type;
    logic            read_done;
    logic            busy;
    logic            feed_done;

    logic [W-1:0]    trn_mem  [NS*E];
    logic [W-1:0]    inp_mem  [E];
    logic [TW-1:0]   type_mem [NS];

    int n_tests = 0;
    int n_fail  = 0;
    int fd_count = 0;
    int rd_count = 0;
    int rec_tlo [NS][NB];
    int rec_thi [NS][NB];
    int rec_ilo [NS][NB];
    int rec_ihi [NS][NB];
    int rec_lat [NS][NB];
    vec_t tbl [6];

    always #5 clk = ~clk;

    knn_data_feeder #(
        .M            (M),
        .N            (N),
        .W            (W),
        .MAX_ELEMENTS (MAXE),
        .TYPE_W       (TW),
        .L            (L)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .data_request       (data_request),
        .done               (done),
        .inference_done     (inference_done),
        .trn_addr           (trn_addr),
        .trn_rdata          (trn_rdata),
        .inp_addr           (inp_addr),
        .inp_rdata          (inp_rdata),
        .type_addr          (type_addr),
        .type_rdata         (type_rdata),
        .training_data      (training_data),
        .input_data         (input_data),
        .training_data_type (training_data_type),
        .read_done          (read_done),
        .busy               (busy),
        .feed_done          (feed_done)
    );

    always @(posedge clk) begin
        trn_rdata  <= trn_mem[trn_addr];
        inp_rdata  <= inp_mem[inp_addr];
        type_rdata <= type_mem[type_addr];
    end

    always @(negedge clk) begin
        if (feed_done === 1'b1) fd_count++;
        if (read_done === 1'b1) rd_count++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    function automatic int burst_len(input int b);
        int r;
        r = E - b * C;
        return (r < C) ? r : C;
    endfunction

    function automatic int count_bad(input int s, input int b);
        int bad;
        int len;
        logic [W-1:0] et;
        logic [W-1:0] ei;
        bad = 0;
        len = burst_len(b);
        for (int k = 0; k < E; k++) begin
            et = (k < len) ? trn_mem[s*E + b*C + k] : '0;
            ei = (k < len) ? inp_mem[b*C + k] : '0;
            if (training_data[k*W +: W] !== et) bad++;
            if (input_data[k*W +: W] !== ei) bad++;
        end
        return bad;
    endfunction

    task automatic init_mem();
        for (int i = 0; i < NS*E; i++) trn_mem[i] = $urandom();
        for (int i = 0; i < E; i++) inp_mem[i] = $urandom();
        for (int i = 0; i < NS; i++) type_mem[i] = TW'($urandom_range(0, (1 << TW) - 1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_trn_addr"}, longint'(trn_addr), 0);
        check({tag, "_inp_addr"}, longint'(inp_addr), 0);
        check({tag, "_type_addr"}, longint'(type_addr), 0);
        check({tag, "_buses_zero"}, longint'((training_data == '0) && (input_data == '0)), 1);
        check({tag, "_type"}, longint'(training_data_type), 0);
        check({tag, "_read_done"}, longint'(read_done), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_feed_done"}, longint'(feed_done), 0);
    endtask

    // Called at cycle 0 of a fetch; returns at the negedge of the read_done cycle
    task automatic wait_burst(input int s, input int b);
        int lat;
        int tlo;
        int thi;
        int ilo;
        int ihi;
        lat = 0;
        tlo = 1 << 30;
        thi = -1;
        ilo = 1 << 30;
        ihi = -1;
        while (read_done !== 1'b1 && lat < 300) begin
            if (int'(trn_addr) < tlo) tlo = int'(trn_addr);
            if (int'(trn_addr) > thi) thi = int'(trn_addr);
            if (int'(inp_addr) < ilo) ilo = int'(inp_addr);
            if (int'(inp_addr) > ihi) ihi = int'(inp_addr);
            @(negedge clk);
            lat++;
        end
        check($sformatf("read_done_s%0d_b%0d", s, b), longint'(read_done), 1);
        rec_tlo[s][b] = tlo;
        rec_thi[s][b] = thi;
        rec_ilo[s][b] = ilo;
        rec_ihi[s][b] = ihi;
        rec_lat[s][b] = lat;
        check($sformatf("latency_s%0d_b%0d", s, b), lat, burst_len(b) + 1);
        check($sformatf("type_s%0d", s), longint'(training_data_type), longint'(type_mem[s]));
        check($sformatf("words_s%0d_b%0d", s, b), count_bad(s, b), 0);
    endtask

    task automatic run_feed(input bit hold, input bit spur_en, input int abort_s);
        int fd0;
        int rd0;
        bit more;
        bit spur;
        fd0 = fd_count;
        rd0 = rd_count;
        @(negedge clk);
        if (hold) begin
            done = 1'b1;
            data_request = 1'b1;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", longint'(busy), 1);
        check("start_addr", longint'(trn_addr), 0);
        for (int s = 0; s < NS; s++) begin
            for (int b = 0; b < NB; b++) begin
                if (s == abort_s && b == 0) begin
                    repeat (10) @(negedge clk);
                    check("abort_trn_addr", longint'(trn_addr), abort_s * E + 10);
                    check("abort_inp_addr", longint'(inp_addr), 10);
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check_all_zero("abort");
                    repeat (3) @(negedge clk);
                    check("abort_stays_idle", longint'(busy), 0);
                    return;
                end
                wait_burst(s, b);
                more = (b < NB - 1);
                if (hold) begin
                    @(negedge clk);
                    check("read_done_width", longint'(read_done), 0);
                    @(negedge clk);
                end else begin
                    spur = spur_en && ($urandom_range(0, 1) == 1);
                    if (spur) begin
                        data_request = 1'b1;
                        done = 1'b1;
                        inference_done = 1'b1;
                        start = 1'b1;
                    end
                    @(negedge clk);
                    data_request = 1'b0;
                    done = 1'b0;
                    inference_done = 1'b0;
                    start = 1'b0;
                    check("read_done_width", longint'(read_done), 0);
                    if (spur) begin
                        if (more) done = 1'b1;
                        else data_request = 1'b1;
                        inference_done = 1'b1;
                        start = 1'b1;
                        @(negedge clk);
                        done = 1'b0;
                        data_request = 1'b0;
                        inference_done = 1'b0;
                        start = 1'b0;
                    end
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    check($sformatf("bus_stable_s%0d_b%0d", s, b), count_bad(s, b), 0);
                    check("busy_waiting", longint'(busy), 1);
                    if (more) data_request = 1'b1;
                    else done = 1'b1;
                    @(negedge clk);
                    data_request = 1'b0;
                    done = 1'b0;
                end
            end
        end
        done = 1'b0;
        data_request = 1'b0;
        if (spur_en) begin
            start = 1'b1;
            data_request = 1'b1;
            done = 1'b1;
            @(negedge clk);
            start = 1'b0;
            data_request = 1'b0;
            done = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("busy_in_inf", longint'(busy), 1);
        check("no_early_feed_done", fd_count - fd0, 0);
        inference_done = 1'b1;
        @(negedge clk);
        inference_done = 1'b0;
        check("feed_done_pulse", longint'(feed_done), 1);
        check("busy_cleared", longint'(busy), 0);
        @(negedge clk);
        check("feed_done_width", longint'(feed_done), 0);
        check("feed_done_count", fd_count - fd0, 1);
        check("burst_count", rd_count - rd0, NS * NB);
    endtask

    initial begin
        tbl[0] = '{0, 0,   0,  63,  0, 63, 65};
        tbl[1] = '{0, 1,  64,  99, 64, 99, 37};
        tbl[2] = '{3, 0, 300, 363,  0, 63, 65};
        tbl[3] = '{3, 1, 364, 399, 64, 99, 37};
        tbl[4] = '{7, 0, 700, 763,  0, 63, 65};
        tbl[5] = '{7, 1, 764, 799, 64, 99, 37};

        rst = 1'b1;
        start = 1'b0;
        data_request = 1'b0;
        done = 1'b0;
        inference_done = 1'b0;
        init_mem();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        run_feed(1'b0, 1'b1, -1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("tbl%0d_trn_lo", i), rec_tlo[tbl[i].s][tbl[i].b], tbl[i].tlo);
            check($sformatf("tbl%0d_trn_hi", i), rec_thi[tbl[i].s][tbl[i].b], tbl[i].thi);
            check($sformatf("tbl%0d_inp_lo", i), rec_ilo[tbl[i].s][tbl[i].b], tbl[i].ilo);
            check($sformatf("tbl%0d_inp_hi", i), rec_ihi[tbl[i].s][tbl[i].b], tbl[i].ihi);
            check($sformatf("tbl%0d_lat", i), rec_lat[tbl[i].s][tbl[i].b], tbl[i].lat);
        end

        init_mem();
        run_feed(1'b1, 1'b0, -1);

        init_mem();
        run_feed(1'b0, 1'b1, 5);

        init_mem();
        run_feed(1'b0, 1'b0, -1);
        check("restart_first_addr", rec_tlo[0][0], 0);

        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst_over_start", longint'(busy), 0);
        repeat (3) @(negedge clk);
        check("rst_over_start_idle", longint'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
